// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared encodings and types for the compare interrupt controller
package cmp_pkg;

   localparam logic [1:0] CFG_VALUE   = 2'd0;
   localparam logic [1:0] CFG_PERIOD  = 2'd1;
   localparam logic [1:0] CFG_CTRL    = 2'd2;
   localparam logic [1:0] CFG_CLR_OVR = 2'd3;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_PER = 1;

   typedef enum logic {
      IDLE   = 1'b0,
      ASSERT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/cmp_irq_ctrl_if.sv
// rtl/cmp_irq_ctrl_if.sv - config write bus and interrupt handshake bundle
interface cmp_irq_ctrl_if #(parameter int CH_W = 2);

   logic            cfg_we;
   logic [CH_W-1:0] cfg_chan;
   logic [1:0]      cfg_sel;
   logic [31:0]     cfg_wdata;
   logic            irq_valid;
   logic [CH_W-1:0] irq_chan;
   logic            irq_ack;

   modport master (
      output cfg_we, cfg_chan, cfg_sel, cfg_wdata, irq_ack,
      input  irq_valid, irq_chan
   );

   modport slave (
      input  cfg_we, cfg_chan, cfg_sel, cfg_wdata, irq_ack,
      output irq_valid, irq_chan
   );

endinterface

// File: rtl/cmp_channel.sv
// rtl/cmp_channel.sv - one compare channel: value/period/ctrl registers, match, reload and one-shot
module cmp_channel
   import cmp_pkg::*;
(
   input  logic        clk_in,
   input  logic        reset,
   input  logic [31:0] counter,
   input  logic        wr_value,
   input  logic        wr_period,
   input  logic        wr_ctrl,
   input  logic [31:0] wdata,
   output logic        match
);

   logic [31:0] value;
   logic [31:0] period;
   logic        enable;
   logic        periodic;

   assign match = enable && (counter == value);

   // Config writes come last so they override the reload/one-shot update of the same edge.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         value    <= '0;
         period   <= '0;
         enable   <= 1'b0;
         periodic <= 1'b0;
      end else begin
         if (match) begin
            if (periodic) value  <= value + period;
            else          enable <= 1'b0;
         end
         if (wr_value)  value  <= wdata;
         if (wr_period) period <= wdata;
         if (wr_ctrl) begin
            enable   <= wdata[CTRL_EN];
            periodic <= wdata[CTRL_PER];
         end
      end
   end

endmodule

// File: rtl/cmp_irq_ctrl.sv
// rtl/cmp_irq_ctrl.sv - compare channels with pending/overrun latching and round-robin interrupt arbiter
module cmp_irq_ctrl
   import cmp_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic [31:0]       counter,
   cmp_irq_ctrl_if.slave     bus,
   output logic [NUM_CH-1:0] pending,
   output logic [NUM_CH-1:0] overrun
);

   logic [NUM_CH-1:0] match;
   logic [NUM_CH-1:0] cfg_hit;
   logic [NUM_CH-1:0] ack_hit;
   arb_state_t        state, state_n;
   logic [CH_W-1:0]   chan_q, chan_n;
   logic [CH_W-1:0]   rr_ptr, rr_n;
   logic [CH_W-1:0]   sel;
   logic              found;
   int                idx;

   always_comb begin
      cfg_hit = '0;
      ack_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cfg_hit[i] = bus.cfg_we && (bus.cfg_chan == CH_W'(i));
         ack_hit[i] = (state == ASSERT) && bus.irq_ack && (chan_q == CH_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      cmp_channel u_ch (
         .clk_in    (clk_in),
         .reset     (reset),
         .counter   (counter),
         .wr_value  (cfg_hit[g] && (bus.cfg_sel == CFG_VALUE)),
         .wr_period (cfg_hit[g] && (bus.cfg_sel == CFG_PERIOD)),
         .wr_ctrl   (cfg_hit[g] && (bus.cfg_sel == CFG_CTRL)),
         .wdata     (bus.cfg_wdata),
         .match     (match[g])
      );
   end

   // A fresh match beats an acknowledge on the same edge and is flagged as an overrun.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         pending <= '0;
         overrun <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            pending[i] <= match[i] | (pending[i] & ~ack_hit[i]);
            if (match[i] && pending[i])
               overrun[i] <= 1'b1;
            else if (cfg_hit[i] && (bus.cfg_sel == CFG_CLR_OVR))
               overrun[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_CH;
         if (!found && pending[idx]) begin
            found = 1'b1;
            sel   = CH_W'(idx);
         end
      end
   end

   always_comb begin
      state_n = state;
      chan_n  = chan_q;
      rr_n    = rr_ptr;
      case (state)
         IDLE: begin
            if (found) begin
               state_n = ASSERT;
               chan_n  = sel;
            end
         end
         ASSERT: begin
            if (bus.irq_ack) begin
               state_n = IDLE;
               rr_n    = (int'(chan_q) == NUM_CH - 1) ? '0 : chan_q + CH_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         chan_q <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_n;
         chan_q <= chan_n;
         rr_ptr <= rr_n;
      end
   end

   assign bus.irq_valid = (state == ASSERT);
   assign bus.irq_chan  = chan_q;

endmodule
